// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// idx_w() sizes index fields so a 1-requester corner still gets a 1-bit index.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 4;
  localparam int DEF_HOLD_CYCLES = 0;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating find-first-set: first set bit of req at or after ptr,
// wrapping modulo N; returns one-hot, index and any-set flag.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Walk from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    pos    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      pos = sum[IW-1:0];
      if (req[pos]) begin
        onehot      = '0;
        onehot[pos] = 1'b1;
        idx         = pos;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter driving one registered shared bus, 1-cycle accept-to-valid,
// optional idle gap after each beat; ARB_LOCK_EN adds per-requester bus locking.
module rr_bus_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_W-1:0]             bus_out,
  output logic                          bus_valid,
  input  logic                          bus_ready,
  output logic [idx_w(NUM_REQ)-1:0]     grant_id
);

  localparam int IW = idx_w(NUM_REQ);

  state_t          state, state_nxt;
  logic [3:0]      hold_cnt, hold_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] pick_req, win_oh;
  logic [IW-1:0]   win_idx, ptr_adv;
  logic            win_any, accept_ok, accept, keep_ptr;

`ifdef ARB_LOCK_EN
  logic            lock_active;
  logic [IW-1:0]   lock_id;

  // A held lock masks every requester except its owner.
  always_comb begin
    pick_req = req_valid;
    if (lock_active) begin
      pick_req          = '0;
      pick_req[lock_id] = req_valid[lock_id];
    end
  end

  assign keep_ptr = lock_active && req_lock[win_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_id     <= '0;
    end else if (accept) begin
      if (lock_active) begin
        if (!req_lock[win_idx]) lock_active <= 1'b0;
      end else if (req_lock[win_idx]) begin
        lock_active <= 1'b1;
        lock_id     <= win_idx;
      end
    end
  end
`else
  assign pick_req = req_valid;
  assign keep_ptr = 1'b0;
`endif

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (pick_req),
    .ptr    (rr_ptr),
    .onehot (win_oh),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign accept_ok = (state == IDLE) ||
                     ((state == XFER) && bus_ready && (HOLD_CYCLES == 0));
  assign accept    = accept_ok && win_any && !rst;
  assign req_ready = accept ? win_oh : '0;
  assign ptr_adv   = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: if (accept) state_nxt = XFER;
      XFER: begin
        if (bus_ready) begin
          if (HOLD_CYCLES > 0) begin
            state_nxt = HOLD;
            hold_nxt  = 4'(HOLD_CYCLES - 1);
          end else if (!accept) begin
            state_nxt = IDLE;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == 4'd0) state_nxt = IDLE;
        else                  hold_nxt  = hold_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= 4'd0;
      rr_ptr    <= '0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      grant_id  <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      bus_valid <= (state_nxt == XFER);
      if (accept) begin
        bus_out  <= req_data[win_idx*DATA_W +: DATA_W];
        grant_id <= win_idx;
        if (!keep_ptr) rr_ptr <= ptr_adv;
      end
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed bench: one arbiter with no idle gap and one with a 3-cycle gap
// share stimulus; expectations are hand-computed per step.
module tb_rr_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_lock;
  logic [15:0] req_data;
  logic        bus_ready;

  logic [3:0]  req_ready0, req_ready3;
  logic [3:0]  bus_out0, bus_out3;
  logic        bus_valid0, bus_valid3;
  logic [1:0]  grant_id0, grant_id3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
`ifdef ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_data  (req_data),
    .req_ready (req_ready0),
    .bus_out   (bus_out0),
    .bus_valid (bus_valid0),
    .bus_ready (bus_ready),
    .grant_id  (grant_id0)
  );

  rr_bus_arbiter #(.NUM_REQ(4), .DATA_W(4), .HOLD_CYCLES(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
`ifdef ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_data  (req_data),
    .req_ready (req_ready3),
    .bus_out   (bus_out3),
    .bus_valid (bus_valid3),
    .bus_ready (bus_ready),
    .grant_id  (grant_id3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle inputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_rr [6];
    logic       exp_bv [6];

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_lock  = 4'b0000;
    req_data  = {4'h4, 4'h3, 4'h2, 4'h1};
    bus_ready = 1'b1;

    // Reset held three cycles with every requester valid.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_req_ready", 32'(req_ready0), 32'h0);
      check("rst_bus_valid", 32'(bus_valid0), 32'h0);
      check("rst_bus_out",   32'(bus_out0),   32'h0);
      check("rst_grant_id",  32'(grant_id0),  32'h0);
    end
    rst = 1'b0;
    #1;

    // Fairness: back-to-back grants 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      check("rr_req_ready", 32'(req_ready0), 32'(4'b0001 << (k % 4)));
      tick();
      check("rr_grant_id",  32'(grant_id0),  32'(k % 4));
      check("rr_bus_valid", 32'(bus_valid0), 32'h1);
      check("rr_bus_out",   32'(bus_out0),   32'((k % 4) + 1));
    end

    // Drain to IDLE, then backpressure a beat from requester 2.
    req_valid = 4'b0000;
    tick();
    check("drain_bus_valid", 32'(bus_valid0), 32'h0);
    req_data[11:8] = 4'hA;
    req_valid      = 4'b0100;
    bus_ready      = 1'b0;
    #1;
    check("bp_first_ready", 32'(req_ready0), 32'b0100);
    tick();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_bus_out",   32'(bus_out0),   32'hA);
      check("bp_bus_valid", 32'(bus_valid0), 32'h1);
      check("bp_grant_id",  32'(grant_id0),  32'h2);
      check("bp_req_ready", 32'(req_ready0), 32'h0);
      tick();
    end
    bus_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready0), 32'b1000);
    tick();
    check("bp_release_grant", 32'(grant_id0), 32'h3);

    // Hold gap on the 3-cycle instance: XFER, three HOLD cycles, IDLE, XFER.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("hold_first_ready", 32'(req_ready3), 32'b0001);
    tick();
    exp_bv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_rr = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int c = 0; c < 6; c++) begin
      check($sformatf("hold_bus_valid_%0d", c), 32'(bus_valid3), 32'(exp_bv[c]));
      check($sformatf("hold_req_ready_%0d", c), 32'(req_ready3), 32'(exp_rr[c]));
      if (c < 5) tick();
    end
    check("hold_second_grant", 32'(grant_id3), 32'h1);

    // Reset in the middle of an XFER that holds 4'h5 from requester 1.
    req_valid = 4'b0000;
    tick();
    tick();
    req_data[7:4] = 4'h5;
    req_valid     = 4'b0010;
    bus_ready     = 1'b0;
    tick();
    check("mid_bus_out",   32'(bus_out0),   32'h5);
    check("mid_grant_id",  32'(grant_id0),  32'h1);
    check("mid_bus_valid", 32'(bus_valid0), 32'h1);
    rst       = 1'b1;
    req_valid = 4'b0110;
    #1;
    check("mid_rst_ready", 32'(req_ready0), 32'h0);
    tick();
    check("mid_rst_bus_valid", 32'(bus_valid0), 32'h0);
    check("mid_rst_bus_out",   32'(bus_out0),   32'h0);
    rst       = 1'b0;
    bus_ready = 1'b1;
    #1;
    check("mid_after_ready", 32'(req_ready0), 32'b0010);
    tick();
    check("mid_after_grant", 32'(grant_id0), 32'h1);

`ifdef ARB_LOCK_EN
    // Lock: requester 1 locks twice then releases while 0 and 3 wait.
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    req_valid = 4'b0001;
    tick();
    check("lock_pre_grant", 32'(grant_id0), 32'h0);
    req_valid = 4'b1011;
    req_lock  = 4'b0010;
    #1;
    check("lock1_ready", 32'(req_ready0), 32'b0010);
    tick();
    check("lock1_grant", 32'(grant_id0), 32'h1);
    check("lock2_ready", 32'(req_ready0), 32'b0010);
    tick();
    check("lock2_grant", 32'(grant_id0), 32'h1);
    req_lock = 4'b0000;
    #1;
    check("lock3_ready", 32'(req_ready0), 32'b0010);
    tick();
    check("lock3_grant", 32'(grant_id0), 32'h1);
    tick();
    check("lock4_grant", 32'(grant_id0), 32'h3);
    tick();
    check("lock5_grant", 32'(grant_id0), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
